xnor_wordgate: RTL and testbench
================================

Name: xnor_wordgate

Overview:
Parameterised word-wide bitwise XNOR gate, used as a logic-unit leaf inside the 64-bit ALU. It provides a combinational XNOR result that is valid in the same cycle as the inputs. It also provides a registered result with match statistics: an equality flag and a count of matching bit positions, which the ALU uses for compare/flag paths. Operands are treated as raw bit vectors; signedness never changes the result bits.

Parameters:
w, 64, operand and result width in bits; legal range 1..64; testbenches instantiate w=8 and w=16.
CW, $clog2(w+1), derived local parameter; width of the match count (w=8 gives 4, w=16 gives 5).

Ports:
clk  input  1  rising-edge clock for the registered outputs
rst  input  1  synchronous, active-high reset
in_0  input  w  operand A (may be driven from a signed source; treated as bits)
in_1  input  w  operand B
en  input  1  capture enable for the registered outputs
XNOR  output  w  combinational result ~(in_0 ^ in_1)
XNOR_q  output  w  registered copy of XNOR
eq_q  output  1  registered flag: 1 when in_0 == in_1, i.e. XNOR is all ones
match_cnt_q  output  CW  registered number of 1 bits in XNOR (0..w)
valid_q  output  1  registered data-valid flag

Behaviour:
- XNOR[i] = ~(in_0[i] ^ in_1[i]) for every i in 0..w-1. Purely combinational, zero latency, independent of clk, rst and en.
- XNOR has no reset value. It follows the inputs at all times, including while rst=1.
- On a rising clk edge with rst=1: XNOR_q=0, eq_q=0, match_cnt_q=0, valid_q=0. Reset takes priority over en.
- On a rising clk edge with rst=0 and en=1 (one-cycle latency):
  - XNOR_q <= XNOR
  - eq_q <= &XNOR
  - match_cnt_q <= popcount(XNOR)
  - valid_q <= 1
- On a rising clk edge with rst=0 and en=0: all registered outputs hold their values, including valid_q.
- Reset asserted mid-stream clears the registered outputs on that edge. The first capture after reset is the first edge with rst=0 and en=1.
- Registered outputs are mutually consistent:
  - eq_q=1 exactly when match_cnt_q==w.
  - match_cnt_q==0 exactly when in_1 was the bitwise complement of in_0.
- Width rules:
  - No sign extension or arithmetic anywhere.
  - match_cnt_q is unsigned and never overflows, because CW bits always hold w.
- X/Z on inputs propagate bitwise per standard XNOR semantics; the design does not filter them.

Decomposition:
- Shared package alu_pkg: the ALU width constant ALU_W=64, used as the default for w.
- One natural sub-module: xnor_popcount. It is a combinational, parameterised adder-tree population count of a w-bit vector producing CW bits, and the parent instantiates it once.
- The XNOR gate array and the output registers stay in the parent.

Test Plan:
1. w=8, in_0=8'hA5, in_1=8'h5A, en=1 -> XNOR=8'h00 immediately; after one edge XNOR_q=8'h00, eq_q=0, match_cnt_q=0, valid_q=1.
2. w=8, in_0=8'hF0, in_1=8'hF0 -> XNOR=8'hFF; next edge eq_q=1, match_cnt_q=8. Then in_0=-1 (8'hFF), in_1=0 -> XNOR=8'h00 and match_cnt_q=0.
3. w=16, in_0=16'h1234, in_1=16'hFFFF -> XNOR=16'h1234; next edge match_cnt_q=5, eq_q=0.
4. Hold, w=8: capture in_0=8'h0F, in_1=8'h00 (XNOR=8'hF0, cnt=4), then set en=0 and change inputs to 8'hFF/8'hFF. XNOR updates to 8'hFF at once; XNOR_q stays 8'hF0 and match_cnt_q stays 4 across 3 edges.
5. Reset: rst=1 with en=1 and non-zero inputs -> after the edge all registered outputs are 0 and valid_q=0, while XNOR still equals ~(in_0^in_1).
6. Random sweep, 10 signed pairs per width (w=8, w=16), 10 time units apart -> XNOR matches the reference model each step. On each enabled edge: XNOR_q matches, match_cnt_q equals the model popcount, and eq_q equals (in_0==in_1).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU constants used by the logic-unit leaves.
package alu_pkg;

    // Native datapath width of the ALU; default width for leaf units.
    localparam int unsigned ALU_W = 64;

endpackage : alu_pkg

// File: rtl/xnor_popcount.sv
// Combinational population count of a w-bit vector, built as a binary adder tree.
module xnor_popcount #(
    parameter int unsigned w = 8,
    localparam int unsigned CW = $clog2(w + 1)
) (
    input  logic [w-1:0]  bits,
    output logic [CW-1:0] count
);

    // Leaves are padded up to a power of two so the tree is always complete.
    localparam int unsigned LW = (w > 1) ? $clog2(w) : 0;
    localparam int unsigned P  = 1 << LW;

    logic [P-1:0] padded;

    // Zero-pad the input so unused leaves contribute nothing.
    always_comb begin
        padded         = '0;
        padded[w-1:0]  = bits;
    end

    // Heap-ordered tree: leaves at P-1..2P-2, node n sums children 2n+1 and 2n+2.
    // Every partial sum is at most w, so CW bits never overflow.
    always_comb begin
        logic [CW-1:0] node [2*P-1];
        for (int i = 0; i < int'(P); i++) begin
            node[int'(P) - 1 + i] = CW'(padded[i]);
        end
        for (int n = int'(P) - 2; n >= 0; n--) begin
            node[n] = node[2*n + 1] + node[2*n + 2];
        end
        count = node[0];
    end

endmodule : xnor_popcount

// File: rtl/xnor_wordgate.sv
// Word-wide bitwise XNOR with a combinational result and a registered result
// carrying equality and matching-bit-count statistics.
module xnor_wordgate
    import alu_pkg::*;
#(
    parameter int unsigned w = ALU_W,
    localparam int unsigned CW = $clog2(w + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [w-1:0]  in_0,
    input  logic [w-1:0]  in_1,
    input  logic          en,
    output logic [w-1:0]  XNOR,
    output logic [w-1:0]  XNOR_q,
    output logic          eq_q,
    output logic [CW-1:0] match_cnt_q,
    output logic          valid_q
);

    logic [CW-1:0] match_cnt;

    // Gate array: operands are raw bits, so no sign handling is involved.
    assign XNOR = ~(in_0 ^ in_1);

    xnor_popcount #(
        .w (w)
    ) u_popcount (
        .bits  (XNOR),
        .count (match_cnt)
    );

    // Capture result and statistics on enabled edges; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            XNOR_q      <= '0;
            eq_q        <= 1'b0;
            match_cnt_q <= '0;
            valid_q     <= 1'b0;
        end else if (en) begin
            XNOR_q      <= XNOR;
            eq_q        <= &XNOR;
            match_cnt_q <= match_cnt;
            valid_q     <= 1'b1;
        end
    end

endmodule : xnor_wordgate

// File: tb/tb_xnor_wordgate.sv
// Self-checking bench for xnor_wordgate at w=8 and w=16 against a bitwise reference model.
module tb_xnor_wordgate;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en8, en16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;

    logic [7:0]  x8, x8_q;
    logic        eq8_q, v8_q;
    logic [3:0]  cnt8_q;
    logic [15:0] x16, x16_q;
    logic        eq16_q, v16_q;
    logic [4:0]  cnt16_q;

    xnor_wordgate #(.w(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_0        (a8),
        .in_1        (b8),
        .en          (en8),
        .XNOR        (x8),
        .XNOR_q      (x8_q),
        .eq_q        (eq8_q),
        .match_cnt_q (cnt8_q),
        .valid_q     (v8_q)
    );

    xnor_wordgate #(.w(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_0        (a16),
        .in_1        (b16),
        .en          (en16),
        .XNOR        (x16),
        .XNOR_q      (x16_q),
        .eq_q        (eq16_q),
        .match_cnt_q (cnt16_q),
        .valid_q     (v16_q)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model state of the registered outputs.
    logic [15:0] m8_q, m16_q;
    int          m8_cnt, m16_cnt;
    logic        m8_eq, m16_eq, m8_v, m16_v;

    // Bit i of the result is 1 when the operands agree at position i.
    function automatic logic [15:0] ref_xnor(input logic [15:0] a, input logic [15:0] b,
                                             input int width);
        logic [15:0] r = '0;
        for (int i = 0; i < width; i++) r[i] = (a[i] == b[i]);
        return r;
    endfunction

    function automatic int ref_matches(input logic [15:0] a, input logic [15:0] b,
                                       input int width);
        int c = 0;
        for (int i = 0; i < width; i++) if (a[i] == b[i]) c++;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one edge using the inputs presented now, then move past the edge.
    task automatic cycle();
        if (rst) begin
            m8_q = '0; m8_cnt = 0; m8_eq = 0; m8_v = 0;
            m16_q = '0; m16_cnt = 0; m16_eq = 0; m16_v = 0;
        end else begin
            if (en8) begin
                m8_q   = ref_xnor({8'h0, a8}, {8'h0, b8}, 8);
                m8_cnt = ref_matches({8'h0, a8}, {8'h0, b8}, 8);
                m8_eq  = (a8 == b8);
                m8_v   = 1'b1;
            end
            if (en16) begin
                m16_q   = ref_xnor(a16, b16, 16);
                m16_cnt = ref_matches(a16, b16, 16);
                m16_eq  = (a16 == b16);
                m16_v   = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_comb(input string tag);
        check({tag, "_x8"},  32'(x8),  32'(ref_xnor({8'h0, a8}, {8'h0, b8}, 8)));
        check({tag, "_x16"}, 32'(x16), 32'(ref_xnor(a16, b16, 16)));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_q8"},    32'(x8_q),   32'(m8_q));
        check({tag, "_eq8"},   32'(eq8_q),  32'(m8_eq));
        check({tag, "_cnt8"},  32'(cnt8_q), 32'(m8_cnt));
        check({tag, "_v8"},    32'(v8_q),   32'(m8_v));
        check({tag, "_q16"},   32'(x16_q),  32'(m16_q));
        check({tag, "_eq16"},  32'(eq16_q), 32'(m16_eq));
        check({tag, "_cnt16"}, 32'(cnt16_q), 32'(m16_cnt));
        check({tag, "_v16"},   32'(v16_q),  32'(m16_v));
    endtask

    initial begin
        rst = 1'b1; en8 = 1'b0; en16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        cycle();
        cycle();
        check_regs("reset");
        check("reset_valid8", 32'(v8_q), 32'h0);
        rst = 1'b0;

        // Complementary operands: no matching bits.
        a8 = 8'hA5; b8 = 8'h5A; en8 = 1'b1;
        #1;
        check("t1_comb", 32'(x8), 32'h00);
        cycle();
        check_regs("t1");
        check("t1_cnt", 32'(cnt8_q), 32'd0);
        check("t1_valid", 32'(v8_q), 32'd1);

        // Equal operands, then -1 against 0.
        a8 = 8'hF0; b8 = 8'hF0;
        #1;
        check("t2_comb", 32'(x8), 32'hFF);
        cycle();
        check("t2_eq", 32'(eq8_q), 32'd1);
        check("t2_cnt", 32'(cnt8_q), 32'd8);
        a8 = 8'(-1); b8 = 8'h00;
        cycle();
        check("t2b_q", 32'(x8_q), 32'h00);
        check("t2b_cnt", 32'(cnt8_q), 32'd0);

        // Wide operand against all ones reproduces the operand.
        en8 = 1'b0;
        a16 = 16'h1234; b16 = 16'hFFFF; en16 = 1'b1;
        #1;
        check("t3_comb", 32'(x16), 32'h1234);
        cycle();
        check("t3_cnt", 32'(cnt16_q), 32'd5);
        check("t3_eq", 32'(eq16_q), 32'd0);
        check_regs("t3");

        // Hold: registered outputs freeze while en=0, combinational path follows inputs.
        en16 = 1'b0;
        a8 = 8'h0F; b8 = 8'h00; en8 = 1'b1;
        cycle();
        check("t4_q", 32'(x8_q), 32'hF0);
        check("t4_cnt", 32'(cnt8_q), 32'd4);
        en8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
        #1;
        check("t4_comb", 32'(x8), 32'hFF);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("t4_hold_q", 32'(x8_q), 32'hF0);
            check("t4_hold_cnt", 32'(cnt8_q), 32'd4);
            check("t4_hold_v", 32'(v8_q), 32'd1);
        end

        // Reset mid-stream beats enable; XNOR keeps following inputs.
        rst = 1'b1; en8 = 1'b1; en16 = 1'b1;
        a8 = 8'h3C; b8 = 8'h0F; a16 = 16'hBEEF; b16 = 16'h1234;
        cycle();
        check_regs("t5");
        check("t5_valid8", 32'(v8_q), 32'd0);
        check("t5_cnt16", 32'(cnt16_q), 32'd0);
        check_comb("t5");
        rst = 1'b0;

        // Random sweep with random enables and occasional equal operands.
        for (int k = 0; k < 10; k++) begin
            a8  = 8'($urandom);  b8  = 8'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) b8 = a8;
            if ($urandom_range(0, 3) == 0) b16 = a16;
            if ($urandom_range(0, 3) == 0) b8 = ~a8;
            en8  = ($urandom_range(0, 3) != 0);
            en16 = ($urandom_range(0, 3) != 0);
            #1;
            check_comb("rnd");
            cycle();
            check_regs("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_xnor_wordgate
